// File: rtl/gaussian_blur.sv
// 3x3 Gaussian blur over a raw-image SRAM: 9-tap fetch with edge clamping, one blurred pixel every 11 cycles.
// Optional macro GAUS_ROUNDING_EN selects round-half-up with saturation instead of truncation.
module gaussian_blur #(
    parameter int X_MAX = 400,
    parameter int Y_MAX = 400
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   new_trans,
    input  logic [$clog2(X_MAX)-1:0] max_x,
    input  logic [$clog2(Y_MAX)-1:0] max_y,
    output logic                   read_SRAM_raw,
    output logic [$clog2(X_MAX):0] x_addr_raw,
    output logic [$clog2(Y_MAX):0] y_addr_raw,
    input  logic [7:0]             SRAM_in_raw,
    output logic                   write_SRAM_gaus,
    output logic [$clog2(X_MAX):0] x_addr_gaus,
    output logic [$clog2(Y_MAX):0] y_addr_gaus,
    output logic [7:0]             SRAM_gaus_wdata,
    output logic                   gaus_sample_flag,
    output logic                   gaus_done
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam logic [XW-1:0] X_ONE = 1;
    localparam logic [YW-1:0] Y_ONE = 1;

    typedef enum logic [2:0] {IDLE, FETCH, ACC, WRITE, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    row, row_nxt, col, col_nxt, wsh;
    logic [XW-1:0] mx, mx_nxt, px, px_nxt, cx;
    logic [YW-1:0] my, my_nxt, py, py_nxt, cy;
    logic [11:0]   acc, acc_nxt, acc_add;
    logic [XW:0]   raw_x_q, gaus_x_q;
    logic [YW:0]   raw_y_q, gaus_y_q;
    logic [7:0]    pix, wdata_q;

    // Tap coordinates: row/col 0..2 map to offset -1..+1, clamped to the frame.
    always_comb begin
        cx = px;
        cy = py;
        if (col == 2'd0 && px != '0)      cx = px - X_ONE;
        if (col == 2'd2 && px != mx - X_ONE) cx = px + X_ONE;
        if (row == 2'd0 && py != '0)      cy = py - Y_ONE;
        if (row == 2'd2 && py != my - Y_ONE) cy = py + Y_ONE;
    end

    // wsh is the log2 kernel weight of the tap whose data arrives this cycle.
    assign acc_add = acc + (12'(SRAM_in_raw) << wsh);

`ifdef GAUS_ROUNDING_EN
    logic [12:0] rnd;
    assign rnd = {1'b0, acc} + 13'd8;
    assign pix = rnd[12] ? 8'hFF : rnd[11:4];
`else
    assign pix = acc[11:4];
`endif

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        mx_nxt    = mx;
        my_nxt    = my;
        px_nxt    = px;
        py_nxt    = py;
        acc_nxt   = acc;
        case (state)
            IDLE, DONE: begin
                if (new_trans) begin
                    mx_nxt    = max_x;
                    my_nxt    = max_y;
                    px_nxt    = '0;
                    py_nxt    = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = (max_x == '0 || max_y == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (row != 2'd0 || col != 2'd0) acc_nxt = acc_add;
                if (col == 2'd2) begin
                    col_nxt = '0;
                    if (row == 2'd2) begin
                        row_nxt   = '0;
                        state_nxt = ACC;
                    end else begin
                        row_nxt = row + 2'd1;
                    end
                end else begin
                    col_nxt = col + 2'd1;
                end
            end
            ACC: begin
                acc_nxt   = acc_add;
                state_nxt = WRITE;
            end
            WRITE: begin
                acc_nxt   = '0;
                state_nxt = FETCH;
                if (px == mx - X_ONE) begin
                    px_nxt = '0;
                    if (py == my - Y_ONE) state_nxt = DONE;
                    else                  py_nxt = py + Y_ONE;
                end else begin
                    px_nxt = px + X_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            mx       <= '0;
            my       <= '0;
            px       <= '0;
            py       <= '0;
            acc      <= '0;
            wsh      <= '0;
            raw_x_q  <= '0;
            raw_y_q  <= '0;
            gaus_x_q <= '0;
            gaus_y_q <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            mx    <= mx_nxt;
            my    <= my_nxt;
            px    <= px_nxt;
            py    <= py_nxt;
            acc   <= acc_nxt;
            if (state == FETCH) begin
                wsh     <= {1'b0, row == 2'd1} + {1'b0, col == 2'd1};
                raw_x_q <= {1'b0, cx};
                raw_y_q <= {1'b0, cy};
            end
            if (state == WRITE) begin
                gaus_x_q <= {1'b0, px};
                gaus_y_q <= {1'b0, py};
                wdata_q  <= pix;
            end
        end
    end

    // Addresses/data drive live in their active state and hold the last value otherwise.
    assign read_SRAM_raw    = (state == FETCH);
    assign write_SRAM_gaus  = (state == WRITE);
    assign gaus_sample_flag = (state == WRITE);
    assign gaus_done        = (state == DONE);
    assign x_addr_raw       = (state == FETCH) ? {1'b0, cx} : raw_x_q;
    assign y_addr_raw       = (state == FETCH) ? {1'b0, cy} : raw_y_q;
    assign x_addr_gaus      = (state == WRITE) ? {1'b0, px} : gaus_x_q;
    assign y_addr_gaus      = (state == WRITE) ? {1'b0, py} : gaus_y_q;
    assign SRAM_gaus_wdata  = (state == WRITE) ? pix : wdata_q;

endmodule

// File: doc/gaussian_blur.md
GAUSSIAN_BLUR -- requirements
Module: gaussian_blur

Interface
REQ-001 SHALL have parameter X_MAX, default 400, meaning maximum image width in pixels.
REQ-002 SHALL have parameter Y_MAX, default 400, meaning maximum image height in pixels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port new_trans, input, 1 bit: frame start request.
REQ-006 SHALL have ports max_x and max_y, inputs, $clog2(X_MAX) bits each: active image width and height, sampled at frame start.
REQ-007 SHALL have port read_SRAM_raw, output, 1 bit: raw image SRAM read enable.
REQ-008 SHALL have ports x_addr_raw and y_addr_raw, outputs, $clog2(X_MAX)+1 bits each: raw SRAM read coordinates.
REQ-009 SHALL have port SRAM_in_raw, input, 8 bits: raw pixel, valid the cycle after read_SRAM_raw is asserted.
REQ-010 SHALL have port write_SRAM_gaus, output, 1 bit: blurred SRAM write enable.
REQ-011 SHALL have ports x_addr_gaus and y_addr_gaus, outputs, $clog2(X_MAX)+1 bits each: blurred SRAM write coordinates.
REQ-012 SHALL have port SRAM_gaus_wdata, output, 8 bits: blurred pixel value.
REQ-013 SHALL have port gaus_sample_flag, output, 1 bit: one-cycle pulse per written pixel.
REQ-014 SHALL have port gaus_done, output, 1 bit: frame-complete level.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, ACC, WRITE and DONE.
REQ-016 IDLE: on new_trans=1 at a clock edge, SHALL latch max_x/max_y, set pixel (0,0) and enter FETCH.
REQ-017 FETCH: SHALL run 9 cycles, tap k=0..8 in row-major order over the 3x3 window (dy,dx in -1..1), read_SRAM_raw=1 each cycle.
REQ-018 Out-of-frame taps SHALL be clamped to the nearest edge coordinate (0 or max-1), giving edge replication.
REQ-019 Each returned tap SHALL be accumulated with kernel weights [1 2 1; 2 4 2; 1 2 1] into a 12-bit unsigned accumulator, cleared at FETCH entry.
REQ-020 ACC (1 cycle): SHALL absorb tap 8; read_SRAM_raw=0.
REQ-021 WRITE (1 cycle): write_SRAM_gaus=1, gaus_sample_flag=1, address = current (x,y), SRAM_gaus_wdata = accumulator>>4 (see REQ-029).
REQ-022 Each pixel SHALL take exactly 11 cycles (9 FETCH, 1 ACC, 1 WRITE), with no idle cycles between pixels.
REQ-023 Pixels SHALL be produced in raster order (x fastest); after the pixel at (max_x-1, max_y-1) the FSM SHALL enter DONE.
REQ-024 DONE: gaus_done=1, held until new_trans=1, which restarts the frame as in REQ-016 and clears gaus_done the same edge.
REQ-025 new_trans SHALL be ignored in FETCH, ACC and WRITE.
REQ-026 max_x or max_y equal to 0 SHALL go straight from IDLE to DONE with no writes; 1x1 frames SHALL replicate the single pixel (output = input).
REQ-027 Enables and flags SHALL be 0 in every state not listed above; addresses hold their last value.

Reset
REQ-028 On n_rst=0, asynchronously: state=IDLE, all enables/flags/gaus_done=0, addresses, wdata, accumulator and latched sizes=0; an in-progress frame is abandoned and not resumed.

Configuration
REQ-029 Macro GAUS_ROUNDING_EN: when defined, SRAM_gaus_wdata = (acc+8)>>4, saturated to 255; when undefined, it is acc>>4 (truncation).

Verification
REQ-030 Uniform 100 image, 8x8 -> all 64 outputs = 100; 64 flag pulses; gaus_done rises 704 cycles after the FETCH entry.
REQ-031 Zero 16x16 image with 255 at (5,5) -> (5,5)=64, (4,5)=32, (4,4)=16 with GAUS_ROUNDING_EN; 63/31/15 without; all other outputs 0.
REQ-032 Zero 4x4 image with 200 at (0,0), clamp test -> output (0,0)=113 (1800/16=112.5) rounded, 112 truncated.
REQ-033 n_rst pulsed low mid-FETCH of pixel 3 -> all outputs 0 immediately; no write follows; next new_trans restarts at (0,0).
REQ-034 new_trans pulsed during WRITE -> ignored, frame order unchanged; in DONE, new_trans -> gaus_done low the next cycle and a new frame starts.
